// File: rtl/sram_bitstream_reader_pkg.sv
// Shared types and constants for the SRAM bitstream reader.
package sram_bitstream_reader_pkg;

  typedef enum logic [1:0] {
    S_BR_IDLE,
    S_BR_FETCH,
    S_BR_EXHAUSTED
  } bitreader_state_type;

  localparam logic [17:0] SRAM_LAST_ADDR = 18'h3FFFF;

  // Lengths above one window are clamped to a full window.
  function automatic logic [4:0] eff_len(input logic [4:0] len);
    return (len > 5'd16) ? 5'd16 : len;
  endfunction

endpackage

// File: rtl/sram_bitstream_reader_if.sv
// SRAM read port plus the peek/consume window of the bitstream reader.
interface sram_bitstream_reader_if;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic [15:0] Bits_window;
  logic        Bits_valid;
  logic        Consume;
  logic [4:0]  Consume_len;

  modport master (
    output SRAM_address, SRAM_we_n, Bits_window, Bits_valid,
    input  SRAM_read_data, Consume, Consume_len
  );

  modport slave (
    input  SRAM_address, SRAM_we_n, Bits_window, Bits_valid,
    output SRAM_read_data, Consume, Consume_len
  );
endinterface

// File: rtl/sram_bitstream_reader_valid_pipe.sv
// Tracks outstanding SRAM reads: a DEPTH-deep valid shift register with flush and popcount.
module sram_bitstream_reader_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       flush,
  input  logic       push,
  output logic       pop,
  output logic [1:0] inflight
);

  logic [DEPTH-1:0] valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      valid_d[0] = push;
      for (int i = 1; i < DEPTH; i++) valid_d[i] = valid_q[i-1];
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < DEPTH; i++) inflight = inflight + 2'(valid_q[i]);
  end

  assign pop = valid_q[DEPTH-1];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) valid_q <= '0;
    else         valid_q <= valid_d;
  end

endmodule

// File: rtl/sram_bitstream_reader.sv
// Sequential SRAM word fetcher feeding an MSB-first bit buffer with variable-length consume.
// Optional Bits_consumed counter is enabled by defining BITREADER_BIT_COUNT_EN.
//
// state           | meaning
// S_BR_IDLE       | no reads issued, waiting for Start
// S_BR_FETCH      | issuing reads whenever the buffer has room for all in-flight words
// S_BR_EXHAUSTED  | last address issued; Fetch_done once outstanding reads land
module sram_bitstream_reader
  import sram_bitstream_reader_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int BUF_BITS     = 64
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Initialize,
  input  logic        Start,
  input  logic [17:0] Start_address,
  sram_bitstream_reader_if.master bus,
  output logic        Fetch_done,
  output logic        Underflow
`ifdef BITREADER_BIT_COUNT_EN
  ,
  output logic [31:0] Bits_consumed
`endif
);

  bitreader_state_type state_q, state_d;
  logic [17:0]         addr_q, addr_d;
  logic [BUF_BITS-1:0] buf_q, buf_d, buf_t;
  logic [6:0]          fill_q, fill_d, fill_t;
  logic                done_q, done_d;
  logic                under_q, under_d;
  logic                issue, flush, arrive, bits_valid;
  logic [1:0]          inflight;
  logic [8:0]          need;
  logic [4:0]          n;
`ifdef BITREADER_BIT_COUNT_EN
  logic [31:0]         cnt_q, cnt_d;
  logic [32:0]         cnt_sum;
`endif

  sram_bitstream_reader_valid_pipe #(.DEPTH(READ_LATENCY)) u_valid_pipe (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .flush    (flush),
    .push     (issue),
    .pop      (arrive),
    .inflight (inflight)
  );

  assign bits_valid = (fill_q >= 7'd16);
  assign n          = eff_len(bus.Consume_len);
  // Room is reserved for every read already in flight plus the one about to issue.
  assign need       = {2'b00, fill_q} + {2'b00, ({1'b0, inflight} + 3'd1), 4'b0000};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    done_d  = done_q;
    under_d = under_q;
    buf_t   = buf_q;
    fill_t  = fill_q;
    issue   = 1'b0;
    flush   = 1'b0;
`ifdef BITREADER_BIT_COUNT_EN
    cnt_d   = cnt_q;
    cnt_sum = {1'b0, cnt_q} + 33'(n);
`endif
    if (Initialize) begin
      state_d = S_BR_IDLE;
      addr_d  = '0;
      buf_d   = '0;
      fill_d  = '0;
      done_d  = 1'b0;
      under_d = 1'b0;
      flush   = 1'b1;
`ifdef BITREADER_BIT_COUNT_EN
      cnt_d   = '0;
`endif
    end else if (Start) begin
      state_d = S_BR_FETCH;
      addr_d  = Start_address;
      buf_d   = '0;
      fill_d  = '0;
      done_d  = 1'b0;
      under_d = 1'b0;
      flush   = 1'b1;
`ifdef BITREADER_BIT_COUNT_EN
      cnt_d   = '0;
`endif
    end else begin
      case (state_q)
        S_BR_FETCH: begin
          if (need <= 9'(BUF_BITS)) begin
            issue = 1'b1;
            if (addr_q != SRAM_LAST_ADDR) addr_d = addr_q + 18'd1;
            else                          state_d = S_BR_EXHAUSTED;
          end
        end
        S_BR_EXHAUSTED: begin
          if (inflight == 2'd0) done_d = 1'b1;
        end
        default: ;
      endcase

      if (bus.Consume) begin
        if (bits_valid) begin
          buf_t  = buf_q << n;
          fill_t = fill_q - {2'b00, n};
`ifdef BITREADER_BIT_COUNT_EN
          cnt_d  = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
`endif
        end else begin
          under_d = 1'b1;
        end
      end
      // Arriving word lands directly behind the bits that survive this cycle's consume.
      if (arrive) begin
        buf_t  = buf_t | ({bus.SRAM_read_data, {(BUF_BITS-16){1'b0}}} >> fill_t);
        fill_t = fill_t + 7'd16;
      end
      buf_d  = buf_t;
      fill_d = fill_t;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_BR_IDLE;
      addr_q  <= '0;
      buf_q   <= '0;
      fill_q  <= '0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
      under_q <= under_d;
    end
  end

`ifdef BITREADER_BIT_COUNT_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
  assign Bits_consumed = cnt_q;
`else
  // Without the counter the effective length only drives the buffer shift.
`endif

  assign bus.SRAM_address = addr_q;
  assign bus.SRAM_we_n    = 1'b1;
  assign bus.Bits_window  = buf_q[BUF_BITS-1 -: 16];
  assign bus.Bits_valid   = bits_valid;
  assign Fetch_done       = done_q;
  assign Underflow        = under_q;

endmodule
